// File: rtl/raw_pattern_pkg.sv
// Shared definitions for the synthetic raw Bayer pattern generator:
// FSM states, pattern mode codes, colour-bar table and Bayer phase helpers.
package raw_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [1:0] BAYER_R = 2'd0;
  localparam logic [1:0] BAYER_G = 2'd1;
  localparam logic [1:0] BAYER_B = 2'd2;

  // Bar index -> {R,G,B} on/off; white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      3'd7:    rgb = 3'b000;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

  // GRBG mosaic: even rows G R G R..., odd rows B G B G...
  function automatic logic [1:0] bayer_phase(input logic x_odd, input logic y_odd);
    logic [1:0] ph;
    if (!y_odd) begin
      ph = x_odd ? BAYER_R : BAYER_G;
    end else begin
      ph = x_odd ? BAYER_G : BAYER_B;
    end
    return ph;
  endfunction

endpackage

// File: rtl/raw_pattern_pixel.sv
// Combinational pattern evaluator: (mode, x, y, solid colour) -> one 10-bit
// Bayer sample. x_off shifts the ramp/checker patterns horizontally; the bar
// pattern and the Bayer phase always use the unshifted x.
module raw_pattern_pixel
  import raw_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [1:0]  mode,
  input  logic [9:0]  x,
  input  logic [9:0]  x_off,
  input  logic        y_odd,
  input  logic        y_blk,
  input  logic [29:0] solid,
  output logic [9:0]  pixel
);

  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;
  localparam int BAR_END = 8 * BAR_W;

  logic [9:0]  xs_s;
  logic [10:0] bar_idx_s;
  logic [2:0]  bar_s;
  logic [9:0]  r_s;
  logic [9:0]  g_s;
  logic [9:0]  b_s;
  logic [9:0]  chk_s;

  // Evaluate the selected pattern as RGB, then pick the mosaic component
  always_comb begin
    xs_s      = x + x_off;
    bar_idx_s = {1'b0, x} / 11'(BAR_DIV);
    bar_s     = 3'b000;
    r_s       = 10'd0;
    g_s       = 10'd0;
    b_s       = 10'd0;
    pixel     = 10'd0;
    chk_s     = (xs_s[5] ^ y_blk) ? 10'h3FF : 10'h000;

    // pixels right of the last full-width bar stay black
    if (({1'b0, x} < 11'(BAR_END)) && (bar_idx_s < 11'd8)) begin
      bar_s = bar_rgb(bar_idx_s[2:0]);
    end else begin
      bar_s = 3'b000;
    end

    case (mode)
      PAT_BARS: begin
        r_s = {10{bar_s[2]}};
        g_s = {10{bar_s[1]}};
        b_s = {10{bar_s[0]}};
      end
      PAT_RAMP: begin
        r_s = xs_s;
        g_s = xs_s;
        b_s = xs_s;
      end
      PAT_CHECK: begin
        r_s = chk_s;
        g_s = chk_s;
        b_s = chk_s;
      end
      PAT_SOLID: begin
        r_s = solid[29:20];
        g_s = solid[19:10];
        b_s = solid[9:0];
      end
      default: begin
        r_s = 10'd0;
        g_s = 10'd0;
        b_s = 10'd0;
      end
    endcase

    case (bayer_phase(x[0], y_odd))
      BAYER_R: pixel = r_s;
      BAYER_G: pixel = g_s;
      BAYER_B: pixel = b_s;
      default: pixel = 10'd0;
    endcase
  end

endmodule

// File: rtl/raw_pattern_gen.sv
// Synthetic raw Bayer source with VS/HS framing, standing in for the camera
// bridge output. Optional feature macro PATGEN_MOVING_EN: when defined, the
// ramp and checker patterns scroll one pixel per completed frame.
module raw_pattern_gen
  import raw_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_LEAD   = 32,
  parameter int V_BLANK  = 8000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [1:0]  iMODE,
  input  logic [29:0] iSOLID,
  output logic [9:0]  oPIXEL_D,
  output logic        oPIXEL_HS,
  output logic        oPIXEL_VS,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY
);

  localparam logic [15:0] LEAD_LAST = 16'(V_LEAD - 1);
  localparam logic [15:0] LINE_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HBL_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VBL_LAST  = 16'(V_BLANK - 1);
  localparam logic [15:0] Y_LAST    = 16'(V_ACTIVE - 1);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [15:0] y_r;
  logic [1:0]  mode_r;
  logic [29:0] solid_r;
  logic [9:0]  d_r;
  logic        hs_r;
  logic        vs_r;
  logic [15:0] fcnt_r;
  logic        busy_r;

  logic [9:0]  nx_s;
  logic [15:0] ny_s;
  logic        lead_go_s;
  logic [9:0]  off_s;
  logic [9:0]  pix_s;

  // Coordinates of the pixel shown next cycle, so the registered D lines up with HS
  always_comb begin
    nx_s      = 10'd0;
    ny_s      = 16'd0;
    lead_go_s = 1'b0;
    if (state_r == ST_LINE) begin
      nx_s = cnt_r[9:0] + 10'd1;
      ny_s = y_r;
    end else if (state_r == ST_HBLANK) begin
      nx_s = 10'd0;
      ny_s = y_r + 16'd1;
    end else begin
      nx_s = 10'd0;
      ny_s = 16'd0;
    end
    if (iEN && ((state_r == ST_IDLE) ||
                ((state_r == ST_VBLANK) && (cnt_r == VBL_LAST)))) begin
      lead_go_s = 1'b1;
    end else begin
      lead_go_s = 1'b0;
    end
  end

`ifdef PATGEN_MOVING_EN
  logic [9:0] off_r;

  // Latch the scroll offset from the completed-frame count at each frame start
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      off_r <= 10'd0;
    end else if (lead_go_s) begin
      off_r <= fcnt_r[9:0];
    end
  end

  assign off_s = off_r;
`else
  assign off_s = 10'd0;
`endif

  raw_pattern_pixel #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pixel (
    .mode  (mode_r),
    .x     (nx_s),
    .x_off (off_s),
    .y_odd (ny_s[0]),
    .y_blk (ny_s[5]),
    .solid (solid_r),
    .pixel (pix_s)
  );

  // Frame sequencer with registered framing, pixel and status outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r <= ST_IDLE;
      cnt_r   <= 16'd0;
      y_r     <= 16'd0;
      mode_r  <= PAT_BARS;
      solid_r <= 30'd0;
      d_r     <= 10'd0;
      hs_r    <= 1'b0;
      vs_r    <= 1'b0;
      fcnt_r  <= 16'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (lead_go_s) begin
            state_r <= ST_LEAD;
            cnt_r   <= 16'd0;
            mode_r  <= iMODE;
            solid_r <= iSOLID;
            vs_r    <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            vs_r    <= 1'b0;
            hs_r    <= 1'b0;
            d_r     <= 10'd0;
            busy_r  <= 1'b0;
          end
        end
        ST_LEAD: begin
          if (cnt_r == LEAD_LAST) begin
            state_r <= ST_LINE;
            cnt_r   <= 16'd0;
            y_r     <= ny_s;
            hs_r    <= 1'b1;
            d_r     <= pix_s;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
          end
        end
        ST_LINE: begin
          if (cnt_r == LINE_LAST) begin
            state_r <= ST_HBLANK;
            cnt_r   <= 16'd0;
            hs_r    <= 1'b0;
            d_r     <= 10'd0;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
            d_r     <= pix_s;
          end
        end
        ST_HBLANK: begin
          if (cnt_r == HBL_LAST) begin
            cnt_r <= 16'd0;
            if (y_r < Y_LAST) begin
              state_r <= ST_LINE;
              y_r     <= ny_s;
              hs_r    <= 1'b1;
              d_r     <= pix_s;
            end else begin
              state_r <= ST_VBLANK;
              vs_r    <= 1'b0;
              fcnt_r  <= fcnt_r + 16'd1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_VBLANK: begin
          if (cnt_r == VBL_LAST) begin
            cnt_r <= 16'd0;
            if (lead_go_s) begin
              state_r <= ST_LEAD;
              mode_r  <= iMODE;
              solid_r <= iSOLID;
              vs_r    <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 16'd0;
          d_r     <= 10'd0;
          hs_r    <= 1'b0;
          vs_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oPIXEL_D   = d_r;
  assign oPIXEL_HS  = hs_r;
  assign oPIXEL_VS  = vs_r;
  assign oFRAME_CNT = fcnt_r;
  assign oBUSY      = busy_r;

endmodule

// File: tb/tb_raw_pattern_gen.sv
// Self-checking bench for raw_pattern_gen: a frame-timeline model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_raw_pattern_gen;

  localparam int HA        = 16;
  localparam int HB        = 4;
  localparam int VA        = 4;
  localparam int VL        = 3;
  localparam int VB        = 5;
  localparam int LINE_T    = HA + HB;
  localparam int VBL_START = VL + VA * LINE_T;
  localparam int PERIOD    = VBL_START + VB;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iEN;
  logic [1:0]  iMODE;
  logic [29:0] iSOLID;
  logic [9:0]  oPIXEL_D;
  logic        oPIXEL_HS;
  logic        oPIXEL_VS;
  logic [15:0] oFRAME_CNT;
  logic        oBUSY;

  always #5 iCLK = ~iCLK;

  raw_pattern_gen #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .V_LEAD   (VL),
    .V_BLANK  (VB)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iEN        (iEN),
    .iMODE      (iMODE),
    .iSOLID     (iSOLID),
    .oPIXEL_D   (oPIXEL_D),
    .oPIXEL_HS  (oPIXEL_HS),
    .oPIXEL_VS  (oPIXEL_VS),
    .oFRAME_CNT (oFRAME_CNT),
    .oBUSY      (oBUSY)
  );

  int checks = 0;
  int errors = 0;

  // model: position in the frame timeline plus per-frame latched settings
  bit          m_active = 1'b0;
  int          m_t      = 0;
  int          m_cnt    = 0;
  int          m_mode   = 0;
  int          m_off    = 0;
  logic [29:0] m_solid  = 30'd0;

  int         n_vs, n_hs, n_busy;
  logic [9:0] cap0 [HA];
  logic [9:0] cap1 [HA];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int model_pix(input int mode, input logic [29:0] solid,
                                   input int x, input int y, input int off);
    int rt[8];
    int gt[8];
    int bt[8];
    int r, g, b, xs, bw, v;
    rt = '{1, 1, 0, 0, 1, 1, 0, 0};
    gt = '{1, 1, 1, 1, 0, 0, 0, 0};
    bt = '{1, 0, 1, 0, 1, 0, 1, 0};
    xs = (x + off) % 1024;
    r = 0; g = 0; b = 0;
    case (mode)
      0: begin
        bw = HA / 8;
        if (bw > 0 && x < 8 * bw) begin
          r = rt[x / bw] * 1023;
          g = gt[x / bw] * 1023;
          b = bt[x / bw] * 1023;
        end
      end
      1: begin r = xs; g = xs; b = xs; end
      2: begin
        v = (((xs / 32) ^ (y / 32)) % 2) != 0 ? 1023 : 0;
        r = v; g = v; b = v;
      end
      default: begin
        r = int'(solid[29:20]);
        g = int'(solid[19:10]);
        b = int'(solid[9:0]);
      end
    endcase
    if (y % 2 == 0) return (x % 2 == 0) ? g : r;
    else            return (x % 2 == 0) ? b : g;
  endfunction

  task automatic model_step();
    if (iRST) begin
      m_active = 1'b0;
      m_t      = 0;
      m_cnt    = 0;
    end else if (!m_active || m_t == PERIOD - 1) begin
      if (iEN) begin
        m_active = 1'b1;
        m_t      = 0;
        m_mode   = int'(iMODE);
        m_solid  = iSOLID;
`ifdef PATGEN_MOVING_EN
        m_off    = m_cnt % 1024;
`else
        m_off    = 0;
`endif
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_t++;
      if (m_t == VBL_START) m_cnt = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic compare();
    int e_vs, e_hs, e_d, u, x, y;
    e_vs = 0; e_hs = 0; e_d = 0; x = 0; y = 0;
    if (m_active) begin
      if (m_t < VL) begin
        e_vs = 1;
      end else if (m_t < VBL_START) begin
        u = m_t - VL;
        y = u / LINE_T;
        x = u % LINE_T;
        e_vs = 1;
        if (x < HA) begin
          e_hs = 1;
          e_d  = model_pix(m_mode, m_solid, x, y, m_off);
        end
      end
    end
    check("vs", int'(oPIXEL_VS), e_vs);
    check("hs", int'(oPIXEL_HS), e_hs);
    check("pixel_d", int'(oPIXEL_D), e_d);
    check("frame_cnt", int'(oFRAME_CNT), m_cnt);
    check("busy", int'(oBUSY), int'(m_active));
    if (oPIXEL_VS) n_vs++;
    if (oPIXEL_HS) n_hs++;
    if (oBUSY)     n_busy++;
    if (e_hs == 1 && y == 0) cap0[x] = oPIXEL_D;
    if (e_hs == 1 && y == 1) cap1[x] = oPIXEL_D;
  endtask

  task automatic tick();
    @(posedge iCLK);
    model_step();
    #1;
    compare();
  endtask

  task automatic clear_stats();
    n_vs = 0; n_hs = 0; n_busy = 0;
    for (int i = 0; i < HA; i++) begin
      cap0[i] = 10'd0;
      cap1[i] = 10'd0;
    end
  endtask

  // one frame requested with a single-cycle enable, then run to idle
  task automatic one_frame(input logic [1:0] mode, input logic [29:0] solid);
    clear_stats();
    iMODE  = mode;
    iSOLID = solid;
    iEN    = 1'b1;
    tick();
    iEN    = 1'b0;
    repeat (PERIOD + 12) tick();
  endtask

  task automatic wait_t(input string name, input int target);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3 * PERIOD && !found; k++) begin
      if (m_active && m_t == target) found = 1'b1;
      else tick();
    end
    check(name, int'(found), 1);
  endtask

  initial begin
    int base;
    iRST = 1'b1; iEN = 1'b0; iMODE = 2'd0; iSOLID = 30'd0;
    clear_stats();
    repeat (3) tick();
    check("rst_d", int'(oPIXEL_D), 0);
    check("rst_busy", int'(oBUSY), 0);
    iRST = 1'b0;
    tick();

    // framing and ramp
    one_frame(2'd1, 30'd0);
    check("vs_len", n_vs, 83);
    check("hs_len", n_hs, 64);
    check("period", n_busy, 88);
    check("fcnt_after_1", int'(oFRAME_CNT), 1);
    for (int i = 0; i < HA; i++) check("ramp_row0", int'(cap0[i]), i);

    // solid colour and Bayer phase
    one_frame(2'd3, {10'd100, 10'd200, 10'd300});
    check("solid_r0x0", int'(cap0[0]), 200);
    check("solid_r0x1", int'(cap0[1]), 100);
    check("solid_r1x0", int'(cap1[0]), 300);
    check("solid_r1x1", int'(cap1[1]), 200);

    // colour bars
    one_frame(2'd0, 30'd0);
    check("bars_x0", int'(cap0[0]), 1023);
    check("bars_x11", int'(cap0[11]), 1023);
    check("bars_x13", int'(cap0[13]), 0);
    check("bars_x15", int'(cap0[15]), 0);

    // mode change and enable drop mid-line 2
    clear_stats();
    iMODE = 2'd1; iEN = 1'b1;
    tick();
    wait_t("wait_line2", VL + 2 * LINE_T + 8);
    iMODE = 2'd2; iEN = 1'b0;
    repeat (PERIOD) tick();
    check("idle_busy", int'(oBUSY), 0);
    check("idle_vs", int'(oPIXEL_VS), 0);
    check("idle_hs", int'(oPIXEL_HS), 0);
    check("idle_d", int'(oPIXEL_D), 0);
    check("fcnt_after_4", int'(oFRAME_CNT), 4);

    // reset during line 2, then a full frame from LEAD
    iMODE = 2'd1; iEN = 1'b1;
    tick();
    wait_t("wait_rst", VL + 2 * LINE_T + 3);
    iRST = 1'b1;
    tick();
    iRST = 1'b0; iEN = 1'b0;
    check("rst_mid_hs", int'(oPIXEL_HS), 0);
    check("rst_mid_vs", int'(oPIXEL_VS), 0);
    check("rst_mid_d", int'(oPIXEL_D), 0);
    check("rst_mid_fcnt", int'(oFRAME_CNT), 0);
    tick();
    one_frame(2'd1, 30'd0);
    check("rst_vs_len", n_vs, 83);
    check("rst_period", n_busy, 88);

    // four back-to-back frames; the fourth starts with frame count 3
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    clear_stats();
    iMODE = 2'd1; iEN = 1'b1;
    tick();
    repeat (3 * PERIOD) tick();
    iEN = 1'b0;
    repeat (PERIOD + 5) tick();
    check("b2b_busy", n_busy, 4 * PERIOD);
`ifdef PATGEN_MOVING_EN
    base = 3;
`else
    base = 0;
`endif
    check("scroll_x0", int'(cap0[0]), base);
    check("scroll_x5", int'(cap0[5]), base + 5);
    check("fcnt_after_b2b", int'(oFRAME_CNT), 4);

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) iEN = ~iEN;
      if ($urandom_range(0, 9) == 0) begin
        iMODE  = 2'($urandom);
        iSOLID = 30'($urandom);
      end
      iRST = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
